r8_sum_ctrl: RTL and testbench

Sequencing controller for the radius-8 (17x17) windowed column-sum datapath. It accepts a stream of 17-pixel column vectors from the line buffer and generates the datapath strobes that drive the running 17-column window sum: load, accumulate, add/subtract, counter and row-start. It tracks frame progress and flags each valid window sum with its output coordinates. It sits between the line-buffer/window generator and the R8 sum datapath, one instance per R8 filter.

---
 rtl/r8_sum_ctrl_if.sv | 30 +++
 rtl/r8_sum_ctrl.sv | 162 ++++++++++++++++
 tb/tb_r8_sum_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/r8_sum_ctrl_if.sv
// Handshake/strobe bundle between the line-buffer feeder, r8_sum_ctrl and the R8 sum datapath.
// valid_i marks a column vector on the datapath input; there is no ready, the controller never stalls.
interface r8_sum_ctrl_if;
    logic       start_i;
    logic       valid_i;
    logic       start_en;
    logic       count_en;
    logic       ld_en;
    logic       sum_en;
    logic       cum_en;
    logic       valid_o;
    logic [9:0] out_col;
    logic [9:0] out_row;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [1:0] dbg_state;

    modport master (
        output start_i, valid_i,
        input  start_en, count_en, ld_en, sum_en, cum_en,
        input  valid_o, out_col, out_row, busy_o, done_o, err_o, dbg_state
    );

    modport slave (
        input  start_i, valid_i,
        output start_en, count_en, ld_en, sum_en, cum_en,
        output valid_o, out_col, out_row, busy_o, done_o, err_o, dbg_state
    );
endinterface

// File: rtl/r8_sum_ctrl.sv
// Sequencing controller for the radius-8 windowed column-sum datapath: frame FSM,
// input column/row tracking, column tag pipeline, accumulator strobes and window tagging.
module r8_sum_ctrl #(
    parameter int COLS     = 32,
    parameter int ROWS     = 32,
    parameter int WIN      = 17,
    parameter int PIPE_LAT = 6
) (
    input logic         clk,
    input logic         rst,
    r8_sum_ctrl_if.slave bus
);

    if (COLS > 1023 || ROWS > 1023 || COLS < WIN || ROWS < WIN || PIPE_LAT < 1) begin : g_param_err
        $error("r8_sum_ctrl: COLS/ROWS must be in WIN..1023 and PIPE_LAT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
    localparam logic [9:0] ROW_LAST  = 10'(ROWS - WIN);
    localparam logic [9:0] WIN_W     = 10'(WIN);
    localparam logic [9:0] WIN_M1    = 10'(WIN - 1);
    localparam logic [9:0] OCOL_LAST = 10'(COLS - WIN);

    state_t              state_q, state_d;
    logic [9:0]          in_col_q, in_col_d;
    logic [9:0]          in_row_q, in_row_d;
    logic [PIPE_LAT-1:0] tv_q, tv_d;
    logic [9:0]          tc_q [PIPE_LAT];
    logic [9:0]          tc_d [PIPE_LAT];
    logic                valid_o_q, valid_o_d;
    logic [9:0]          out_col_q, out_col_d;
    logic [9:0]          out_row_q, out_row_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                t_vld;
    logic [9:0]          t_col;
    logic                pipe_rest;

    assign accept = (state_q == RUN) & bus.valid_i;
    assign t_vld  = tv_q[PIPE_LAT-1];
    assign t_col  = tc_q[PIPE_LAT-1];

    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        err_d     = err_q;
        out_row_d = out_row_q;
        pipe_rest = 1'b0;

        // Younger tags still in flight keep the frame in DRAIN.
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            pipe_rest = pipe_rest | tv_q[i];
        end

        if (valid_o_q && (out_col_q == OCOL_LAST)) begin
            out_row_d = out_row_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d   = RUN;
                    in_col_d  = '0;
                    in_row_d  = '0;
                    out_row_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (in_col_q == COL_LAST) begin
                        in_col_d = '0;
                        if (in_row_q == ROW_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            in_row_d = in_row_q + 10'd1;
                        end
                    end else begin
                        in_col_d = in_col_q + 10'd1;
                    end
                end else if (in_col_q != '0) begin
                    // Mid-row gap: restart the row from column 0, the feeder re-sends it.
                    err_d    = 1'b1;
                    in_col_d = '0;
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tv_d[0] = accept;
        tc_d[0] = in_col_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tc_d[i] = tc_q[i-1];
        end

        valid_o_d = t_vld & (t_col >= WIN_M1);
        out_col_d = valid_o_d ? (t_col - WIN_M1) : out_col_q;
        done_d    = (state_q == DRAIN) & t_vld & ~pipe_rest;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_col_q  <= '0;
            in_row_q  <= '0;
            tv_q      <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tc_q[i] <= '0;
            end
            valid_o_q <= 1'b0;
            out_col_q <= '0;
            out_row_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            tv_q      <= tv_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tc_q[i] <= tc_d[i];
            end
            valid_o_q <= valid_o_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.start_en  = accept & (in_col_q == '0);
    assign bus.count_en  = t_vld;
    assign bus.ld_en     = t_vld & (t_col == '0);
    assign bus.sum_en    = t_vld & (t_col != '0);
    assign bus.cum_en    = t_vld & (t_col >= WIN_W);
    assign bus.valid_o   = valid_o_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_row   = out_row_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_r8_sum_ctrl.sv
// Directed bench for r8_sum_ctrl with COLS=20, ROWS=18: two window rows of four windows per frame.
module tb_r8_sum_ctrl;

    localparam int COLS = 20;
    localparam int ROWS = 18;
    localparam int WIN  = 17;
    localparam int LAT  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_valid = 0;
    int   base;
    bit   mon_en = 1'b0;
    logic [3:0] s_obs;

    // {due cycle, count_en, ld_en, sum_en, cum_en}
    logic [35:0] strb_q[$];
    // {due cycle, out_row, out_col}
    logic [51:0] exp_q[$];

    r8_sum_ctrl_if bus ();

    r8_sum_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .WIN(WIN), .PIPE_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: strobes at their exact due cycle, idle otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            s_obs = {bus.count_en, bus.ld_en, bus.sum_en, bus.cum_en};
            if (strb_q.size() > 0 && strb_q[0][35:4] <= 32'(cyc)) begin
                chk("strobe", {32'(cyc), s_obs}, strb_q[0]);
                void'(strb_q.pop_front());
            end else begin
                chk("strobe_idle", s_obs, 4'b0000);
            end
        end
    end

    // scoreboard: window tags at their exact due cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid_o) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", bus.valid_o, 1'b0);
                end else begin
                    chk("window", {32'(cyc), bus.out_row, bus.out_col}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && exp_q[0][51:20] < 32'(cyc)) begin
                chk("window_missing", {32'(cyc), bus.out_row, bus.out_col}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        strb_q.delete();
        exp_q.delete();
        rst = 1'b0;
        chk("rst_outs", {bus.start_en, bus.count_en, bus.ld_en, bus.sum_en, bus.cum_en,
                         bus.valid_o, bus.out_col, bus.out_row, bus.busy_o, bus.done_o,
                         bus.err_o, bus.dbg_state}, 31'd0);
    endtask

    task automatic start_frame();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("run_after_start", {bus.busy_o, bus.dbg_state}, 3'b101);
    endtask

    task automatic feed_cols(input int row, input int n, input int pulse_col);
        for (int c = 0; c < n; c++) begin
            bus.valid_i = 1'b1;
            bus.start_i = (c == pulse_col);
            strb_q.push_back({32'(cyc + LAT), 1'b1, c == 0, c >= 1, c >= WIN});
            if (c >= WIN - 1) exp_q.push_back({32'(cyc + LAT + 1), 10'(row), 10'(c - (WIN - 1))});
            @(negedge clk);
            chk("start_en", bus.start_en, c == 0);
            tick();
        end
        bus.valid_i = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_done(input bit start_at_done);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.done_o) got = 1'b1;
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("done_with_last", {bus.valid_o, bus.out_row, bus.out_col}, {1'b1, 10'd1, 10'd3});
            bus.start_i = start_at_done;
        end
        tick();
        bus.start_i = 1'b0;
        chk("idle_after_done", {bus.busy_o, bus.done_o, bus.dbg_state}, 4'b0000);
        chk("out_row_end", bus.out_row, 10'd2);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        // valid_i in IDLE is ignored
        bus.valid_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_start_en", bus.start_en, 1'b0);
            tick();
        end
        idle(8);
        chk("idle_stays", {bus.busy_o, bus.dbg_state}, 3'b000);

        // continuous frame
        base = n_valid;
        start_frame();
        feed_cols(0, COLS, -1);
        feed_cols(1, COLS, -1);
        chk("drain_state", bus.dbg_state, 2'd2);
        wait_done(1'b0);
        chk("frame_windows", n_valid - base, 8);
        chk("err_clean", bus.err_o, 1'b0);

        // mid-row gap at column 10 of row 0, row re-fed
        idle(3);
        base = n_valid;
        start_frame();
        feed_cols(0, 10, -1);
        idle(1);
        chk("gap_err", {bus.err_o, bus.dbg_state}, 3'b101);
        idle(10);
        chk("gap_no_windows", n_valid - base, 0);
        feed_cols(0, COLS, -1);
        feed_cols(1, COLS, -1);
        wait_done(1'b0);
        chk("gap_windows", n_valid - base, 8);
        chk("gap_err_sticky", bus.err_o, 1'b1);

        // inter-row gap, start_i pulsed in RUN and again with done_o
        do_reset();
        base = n_valid;
        start_frame();
        feed_cols(0, COLS, -1);
        idle(5);
        chk("row_gap_legal", bus.err_o, 1'b0);
        feed_cols(1, COLS, 18);
        wait_done(1'b1);
        tick();
        chk("start_at_done_ignored", {bus.busy_o, bus.dbg_state}, 3'b000);
        chk("row_gap_windows", n_valid - base, 8);
        chk("row_gap_err", bus.err_o, 1'b0);

        // reset in the middle of row 1
        base = n_valid;
        start_frame();
        feed_cols(0, COLS, -1);
        idle(8);
        chk("row0_windows", n_valid - base, 4);
        feed_cols(1, 8, -1);
        bus.valid_i = 1'b1;
        do_reset();
        repeat (12) tick();
        chk("rst_flush_idle", {bus.busy_o, bus.dbg_state, bus.err_o}, 4'b0000);
        chk("rst_flush_windows", n_valid - base, 4);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
